// File: rtl/vdic_mac_pkg.sv
// Shared types and parameter defaults for the VDIC multiply-accumulate block.
package vdic_mac_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int GUARD_W_DEF = 8;
    localparam int MUL_LAT_DEF = 2;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        MAC  = 2'd1,
        LOAD = 2'd2,
        READ = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vdic_mult_pipe.sv
// Signed DATA_W x DATA_W multiplier followed by a MUL_LAT-deep register pipeline
// with a valid bit travelling alongside the product.
module vdic_mult_pipe
    import vdic_mac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_valid,
    output logic [2*DATA_W-1:0]   o_product
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]      w_a_ext;
    logic [PW-1:0]      w_b_ext;
    logic [PW-1:0]      w_prod;
    logic [PW-1:0]      r_prod [MUL_LAT];
    logic [MUL_LAT-1:0] r_valid;

    // Sign-extending to the full product width lets a plain multiply yield the signed result.
    assign w_a_ext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
    assign w_b_ext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Product and valid shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_prod[0]  <= w_prod;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_prod[i]  <= r_prod[i-1];
            end
        end
    end

    assign o_valid   = r_valid[MUL_LAT-1];
    assign o_product = r_prod[MUL_LAT-1];

endmodule

// File: rtl/vdic_mac_2024.sv
// Multiply / multiply-accumulate unit with operand parity checking, a guarded
// accumulator and an IDLE/BUSY/DONE request-result handshake.
module vdic_mac_2024
    import vdic_mac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GUARD_W = GUARD_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic [DATA_W-1:0]             arg_a,
    input  logic [DATA_W-1:0]             arg_b,
    input  logic                          arg_a_parity,
    input  logic                          arg_b_parity,
    input  logic [1:0]                    mode,
    output logic                          ack,
    output logic [2*DATA_W+GUARD_W-1:0]   result,
    output logic                          result_parity,
    output logic                          arg_parity_error,
    output logic                          overflow,
    output logic                          result_rdy,
    input  logic                          result_ack
);

    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = PW + GUARD_W;

    function automatic logic f_operand_parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    function automatic logic f_acc_parity(input logic [ACC_W-1:0] v);
        return ^v;
    endfunction

    state_t             r_state;
    mode_t              r_mode;
    logic               r_perr;
    logic [ACC_W-1:0]   r_acc;

    logic               w_accept;
    logic               w_perr_in;
    logic               w_pvalid;
    logic [PW-1:0]      w_prod;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_res;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf;

    assign w_accept  = (r_state == IDLE) && req;
    assign w_perr_in = (mode_t'(mode) != READ) &&
                       ((f_operand_parity(arg_a) != arg_a_parity) ||
                        (f_operand_parity(arg_b) != arg_b_parity));

    // Operands go straight into the pipeline on the accepting edge, so the product
    // is ready exactly when BUSY has lasted MUL_LAT cycles.
    vdic_mult_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mult_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_accept),
        .i_a       (arg_a),
        .i_b       (arg_b),
        .o_valid   (w_pvalid),
        .o_product (w_prod)
    );

    assign w_prod_ext = {{GUARD_W{w_prod[PW-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // Result, next accumulator and overflow for the operation now completing.
    always_comb begin
        w_res     = '0;
        w_acc_nxt = r_acc;
        w_ovf     = 1'b0;
        if (r_perr) begin
            w_res = '0;
        end else begin
            case (r_mode)
                MUL: begin
                    w_res = w_prod_ext;
                end
                MAC: begin
                    w_acc_nxt = w_sum;
                    w_res     = w_sum;
                    w_ovf     = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                                (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
                end
                LOAD: begin
                    w_acc_nxt = w_prod_ext;
                    w_res     = w_prod_ext;
                end
                READ: begin
                    w_res = r_acc;
                end
                default: begin
                    w_res = '0;
                end
            endcase
        end
    end

    // Handshake FSM, accumulator and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_mode           <= MUL;
            r_perr           <= 1'b0;
            r_acc            <= '0;
            ack              <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
            overflow         <= 1'b0;
            result_rdy       <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_mode  <= mode_t'(mode);
                        r_perr  <= w_perr_in;
                        ack     <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_pvalid) begin
                        r_acc            <= w_acc_nxt;
                        result           <= w_res;
                        result_parity    <= f_acc_parity(w_res);
                        arg_parity_error <= r_perr;
                        overflow         <= w_ovf;
                        result_rdy       <= 1'b1;
                        r_state          <= DONE;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_rdy <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    result_rdy <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdic_mac_2024.sv
// Scoreboard bench for vdic_mac_2024: a default instance and a GUARD_W=1 instance
// run the same transactions; expectations come from an arithmetic model.
module tb_vdic_mac_2024;

    localparam int MUL_LAT = 2;

    typedef struct packed {
        logic [39:0] res0;
        logic [32:0] res1;
        logic        perr;
        logic        ovf0;
        logic        ovf1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [15:0] arg_a;
    logic [15:0] arg_b;
    logic        arg_a_parity;
    logic        arg_b_parity;
    logic [1:0]  mode;
    logic        result_ack;

    logic        d0_ack, d0_par, d0_perr, d0_ovf, d0_rdy;
    logic [39:0] d0_result;
    logic        d1_ack, d1_par, d1_perr, d1_ovf, d1_rdy;
    logic [32:0] d1_result;

    exp_t              sb_q[$];
    logic signed [39:0] m_acc0;
    logic signed [32:0] m_acc1;
    int                n_chk  = 0;
    int                n_fail = 0;
    logic [39:0]       held;

    always #5 clk = ~clk;

    vdic_mac_2024 #(.DATA_W(16), .GUARD_W(8), .MUL_LAT(MUL_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .arg_a(arg_a), .arg_b(arg_b),
        .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity), .mode(mode),
        .ack(d0_ack), .result(d0_result), .result_parity(d0_par),
        .arg_parity_error(d0_perr), .overflow(d0_ovf), .result_rdy(d0_rdy),
        .result_ack(result_ack)
    );

    vdic_mac_2024 #(.DATA_W(16), .GUARD_W(1), .MUL_LAT(MUL_LAT)) u_dut_g1 (
        .clk(clk), .rst_n(rst_n), .req(req), .arg_a(arg_a), .arg_b(arg_b),
        .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity), .mode(mode),
        .ack(d1_ack), .result(d1_result), .result_parity(d1_par),
        .arg_parity_error(d1_perr), .overflow(d1_ovf), .result_rdy(d1_rdy),
        .result_ack(result_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: full-precision arithmetic, then range test for overflow.
    task automatic push_op(input logic [1:0] md, input logic signed [15:0] a,
                           input logic signed [15:0] b, input logic perr);
        exp_t   e;
        longint p, t;
        e = '0;
        p = longint'(a) * longint'(b);
        e.perr = perr;
        if (!perr) begin
            case (md)
                2'd0: begin
                    e.res0 = p[39:0];
                    e.res1 = p[32:0];
                end
                2'd1: begin
                    t      = longint'(m_acc0) + p;
                    e.ovf0 = (t > 64'sd549755813887) || (t < -64'sd549755813888);
                    m_acc0 = t[39:0];
                    t      = longint'(m_acc1) + p;
                    e.ovf1 = (t > 64'sd4294967295) || (t < -64'sd4294967296);
                    m_acc1 = t[32:0];
                    e.res0 = m_acc0;
                    e.res1 = m_acc1;
                end
                2'd2: begin
                    m_acc0 = p[39:0];
                    m_acc1 = p[32:0];
                    e.res0 = m_acc0;
                    e.res1 = m_acc1;
                end
                default: begin
                    e.res0 = m_acc0;
                    e.res1 = m_acc1;
                end
            endcase
        end
        sb_q.push_back(e);
    endtask

    // Drive one request; returns at the negedge where ack must be high.
    task automatic start_op(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                            input logic fa, input logic fb);
        @(negedge clk);
        req          = 1'b1;
        mode         = md;
        arg_a        = a;
        arg_b        = b;
        arg_a_parity = (^a) ^ fa;
        arg_b_parity = (^b) ^ fb;
        push_op(md, a, b, (md != 2'd3) && (fa || fb));
        @(negedge clk);
        check_eq("ack", {63'd0, d0_ack}, 64'd1);
        check_eq("ack_g1", {63'd0, d1_ack}, 64'd1);
        req = 1'b0;
    endtask

    // Wait (bounded) for result_rdy, then pop and compare the expectation.
    task automatic wait_result();
        int   lat;
        logic got;
        exp_t e;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (d0_rdy) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check_eq("rdy_seen", {63'd0, got}, 64'd1);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            if (got) begin
                check_eq("latency", 64'(lat), 64'(MUL_LAT + 1));
                check_eq("rdy_g1", {63'd0, d1_rdy}, 64'd1);
                check_eq("ack_low", {63'd0, d0_ack}, 64'd0);
                check_eq("result", {24'd0, d0_result}, {24'd0, e.res0});
                check_eq("parity", {63'd0, d0_par}, {63'd0, ^e.res0});
                check_eq("perr", {63'd0, d0_perr}, {63'd0, e.perr});
                check_eq("ovf", {63'd0, d0_ovf}, {63'd0, e.ovf0});
                check_eq("result_g1", {31'd0, d1_result}, {31'd0, e.res1});
                check_eq("parity_g1", {63'd0, d1_par}, {63'd0, ^e.res1});
                check_eq("perr_g1", {63'd0, d1_perr}, {63'd0, e.perr});
                check_eq("ovf_g1", {63'd0, d1_ovf}, {63'd0, e.ovf1});
            end
        end
    endtask

    task automatic release_result();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check_eq("rdy_drop", {63'd0, d0_rdy}, 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq(tag, {24'd0, d0_result} | {31'd0, d1_result}, 64'd0);
        check_eq({tag, "_flags"}, {58'd0, d0_ack, d0_par, d0_perr, d0_ovf, d0_rdy, d1_rdy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; arg_a = 16'd0; arg_b = 16'd0;
        arg_a_parity = 1'b0; arg_b_parity = 1'b0; mode = 2'd0; result_ack = 1'b0;
        m_acc0 = '0; m_acc1 = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Most negative operands, MUL
        start_op(2'd0, 16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_result();
        check_eq("mul_min", {24'd0, d0_result}, 64'h0040000000);
        check_eq("mul_min_par", {63'd0, d0_par}, 64'd1);
        release_result();

        // LOAD / MAC / READ chain
        start_op(2'd2, 16'd3, 16'd4, 1'b0, 1'b0);             wait_result(); release_result();
        start_op(2'd1, -16'sd5, 16'd6, 1'b0, 1'b0);           wait_result();
        check_eq("mac_neg", {24'd0, d0_result}, 64'h000000FFFFFFFFEE & 64'hFF_FFFF_FFFF);
        release_result();
        start_op(2'd3, 16'h1234, 16'h0, 1'b1, 1'b0);          wait_result(); release_result();

        // Parity errors leave the accumulator alone; READ ignores parity
        start_op(2'd2, 16'd7, 16'd7, 1'b0, 1'b0);             wait_result(); release_result();
        start_op(2'd0, 16'd2, 16'd2, 1'b1, 1'b0);             wait_result(); release_result();
        start_op(2'd1, 16'd9, 16'd9, 1'b0, 1'b1);             wait_result(); release_result();
        start_op(2'd3, 16'd0, 16'd0, 1'b1, 1'b1);             wait_result();
        check_eq("read_49", {24'd0, d0_result}, 64'd49);
        release_result();

        // Accumulator overflow with a single guard bit
        start_op(2'd2, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);       wait_result(); release_result();
        for (int k = 0; k < 4; k++) begin
            start_op(2'd1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
            wait_result();
            check_eq("g1_ovf_seq", {63'd0, d1_ovf}, {63'd0, (k == 3)});
            release_result();
        end
        check_eq("g1_wrap", {31'd0, d1_result}, 64'h13FFB0005);

        // Held DONE with req pending
        start_op(2'd1, 16'd3, 16'd5, 1'b0, 1'b0);
        req = 1'b1; mode = 2'd3;
        wait_result();
        held = d0_result;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("hold_ack", {63'd0, d0_ack}, 64'd0);
            check_eq("hold_result", {24'd0, d0_result}, {24'd0, held});
            check_eq("hold_rdy", {63'd0, d0_rdy}, 64'd1);
        end
        push_op(2'd3, 16'd0, 16'd0, 1'b0);
        release_result();
        check_eq("idle_no_ack", {63'd0, d0_ack}, 64'd0);
        @(negedge clk);
        check_eq("pending_ack", {63'd0, d0_ack}, 64'd1);
        req = 1'b0;
        wait_result();
        release_result();

        // Random traffic
        for (int k = 0; k < 24; k++) begin
            start_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            wait_result();
            release_result();
        end

        // Reset in the first BUSY cycle of a MAC
        start_op(2'd2, 16'd11, 16'd13, 1'b0, 1'b0);           wait_result(); release_result();
        start_op(2'd1, 16'd100, 16'd100, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb_q.pop_back());
        m_acc0 = '0; m_acc1 = '0;
        check_zero("busy_reset");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("no_rdy_after_rst", {62'd0, d0_rdy, d1_rdy}, 64'd0);
        end
        start_op(2'd3, 16'd0, 16'd0, 1'b0, 1'b0);
        wait_result();
        check_eq("read_after_rst", {24'd0, d0_result}, 64'd0);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vdic_mac_2024.md
VDIC_MAC_2024 -- requirements
Module: vdic_mac_2024

Interface
REQ-001 Parameter DATA_W, default 16, sets the signed operand width.
REQ-002 Parameter GUARD_W, default 8, sets the accumulator guard bits; ACC_W = 2*DATA_W + GUARD_W.
REQ-003 Parameter MUL_LAT, default 2, sets the multiply pipeline depth in cycles; legal range is MUL_LAT >= 1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 req  in  1  operation request.
REQ-008 arg_a, arg_b  in  DATA_W each  signed operands.
REQ-009 arg_a_parity, arg_b_parity  in  1 each  parity bit, equal to the XOR of all bits of the corresponding operand.
REQ-010 mode  in  2  operation select: 0 MUL, 1 MAC, 2 LOAD, 3 READ.
REQ-011 ack  out  1  one-cycle request-accepted pulse.
REQ-012 result  out  ACC_W  signed result.
REQ-013 result_parity  out  1  XOR of all result bits.
REQ-014 arg_parity_error  out  1  operand parity mismatch detected.
REQ-015 overflow  out  1  signed accumulator overflow occurred on this operation.
REQ-016 result_rdy  out  1  result valid.
REQ-017 result_ack  in  1  consumer accepts the result.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 In IDLE with req=1 sampled, the block SHALL capture the operands, parity bits and mode, drive ack=1 for exactly the next cycle, and enter BUSY.
REQ-020 BUSY SHALL last exactly MUL_LAT cycles, then go to DONE; result_rdy rises MUL_LAT+1 cycles after the sampling edge.
REQ-021 The block SHALL ignore req outside IDLE: no ack, no capture.
REQ-022 In DONE, result, result_parity, arg_parity_error and overflow SHALL stay stable and result_rdy SHALL stay 1 until result_ack=1 is sampled; the FSM then returns to IDLE.
REQ-023 result_ack sampled in the first DONE cycle SHALL be honoured, so DONE lasts 1 cycle.
REQ-024 A new req SHALL be accepted no earlier than the first IDLE cycle after DONE.
REQ-025 The parity check SHALL apply to modes 0-2 only: error = (^arg_a != arg_a_parity) or (^arg_b != arg_b_parity).
REQ-026 On a parity error: result=0, result_parity=0, arg_parity_error=1, overflow=0, accumulator unchanged, latency unchanged.
REQ-027 MUL: result = a*b, full-precision signed, sign-extended to ACC_W; accumulator unchanged.
REQ-028 LOAD: acc <= sign-extended a*b; result = new acc; overflow=0.
REQ-029 MAC: acc <= acc + a*b, two's-complement wrap-around at ACC_W; result = new acc.
REQ-030 MAC: overflow=1 when the operand signs are equal and the sum sign differs.
REQ-031 READ: result = acc; operands and parity are ignored; arg_parity_error=0; overflow=0.
REQ-032 Outside DONE, result, result_parity, arg_parity_error and overflow SHALL hold their previous values.
REQ-033 ack SHALL be 0 outside the one cycle defined in REQ-019.

Reset
REQ-034 When rst_n=0 is sampled at any state, the next cycle SHALL be IDLE with acc=0 and result, result_parity, arg_parity_error, overflow, ack and result_rdy all 0.
REQ-035 An operation in flight at reset SHALL be discarded with no result_rdy.

Structure
REQ-036 Package vdic_mac_pkg SHALL hold the mode_t enum (MUL, MAC, LOAD, READ), the state_t enum (IDLE, BUSY, DONE), and the parameter defaults.
REQ-037 Sub-module vdic_mult_pipe SHALL implement the DATA_W x DATA_W signed multiply as a MUL_LAT-stage pipeline with valid propagation.
REQ-038 The accumulator, parity logic and FSM SHALL reside in vdic_mac_2024.

Verification
REQ-039 MUL, a=0x8000, b=0x8000, valid parity -> ack 1 cycle later; result_rdy 3 cycles after sampling; result=0x0040000000; result_parity=1.
REQ-040 LOAD 3*4, then MAC (-5)*6, then READ -> results 12, -18, -18; overflow=0 throughout.
REQ-041 After LOAD 7*7, MUL 2*2 with arg_a_parity inverted -> result=0, arg_parity_error=1; following READ -> 49.
REQ-042 GUARD_W=1: LOAD 0x7FFF*0x7FFF, then 4x MAC with the same operands -> 4th MAC overflow=1, result=-3221553147; earlier MACs overflow=0.
REQ-043 result_ack held 0 for 10 DONE cycles with req=1 -> no ack and result stable; result_ack=1 -> IDLE, and the pending req is acked in the following cycle.
REQ-044 rst_n=0 in the 1st BUSY cycle after MAC -> no result_rdy; outputs 0; subsequent READ -> 0.
